// File: rtl/systolic_seq.sv
// systolic_seq: command sequencer for the NxN INT8 systolic multiply array.
// Clears the sums, feeds skewed operand lanes, drains, then streams result rows.
module systolic_seq #(
    parameter int N      = 32,
    parameter int K_MAX  = 256,
    parameter int PE_LAT = 1,
    parameter int KW     = $clog2(K_MAX + 1),
    parameter int TW     = $clog2(K_MAX + 2 * N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 acc_clr,
    output logic [TW-1:0]        feed_t,
    output logic [N-1:0]         a_valid,
    output logic [N-1:0]         b_valid,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_row,
    input  logic                 out_ready
);

    localparam int RW = $clog2(N);
    localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((PE_LAT > 0) ? PE_LAT - 1 : 0);
    localparam logic [KW-1:0] K_SAT      = KW'(K_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_READ,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_nx;
    logic [TW-1:0] r_feed_t;
    logic [TW-1:0] w_feed_t_nx;
    logic [DW-1:0] r_drain;
    logic [DW-1:0] w_drain_nx;
    logic [RW-1:0] r_out_row;
    logic [RW-1:0] w_out_row_nx;
    logic          r_busy;
    logic          r_done;
    logic          r_acc_clr;
    logic          r_out_valid;
    logic [N-1:0]  r_mask;
    logic [N-1:0]  w_mask_nx;
    logic [TW:0]   w_feed_last;
    logic [TW:0]   w_t;
    logic [TW:0]   w_kx;

    // Last feed index is k+2N-3; the array needs 2N-2 extra cycles to skew through.
    assign w_feed_last = (TW+1)'(r_k) + (TW+1)'(2 * N - 3);

    always_comb begin
        w_state_nx   = r_state;
        w_k_nx       = r_k;
        w_feed_t_nx  = '0;
        w_drain_nx   = '0;
        w_out_row_nx = r_out_row;
        if (abort) begin
            w_state_nx   = S_IDLE;
            w_out_row_nx = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nx = S_CLEAR;
                        w_k_nx     = (k_len > K_SAT) ? K_SAT : k_len;
                    end
                end
                S_CLEAR: begin
                    w_out_row_nx = '0;
                    w_state_nx   = (r_k == '0) ? S_READ : S_FEED;
                end
                S_FEED: begin
                    if ({1'b0, r_feed_t} == w_feed_last) begin
                        w_state_nx = (PE_LAT == 0) ? S_READ : S_DRAIN;
                    end else begin
                        w_feed_t_nx = r_feed_t + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        w_state_nx = S_READ;
                    end else begin
                        w_drain_nx = r_drain + 1'b1;
                    end
                end
                S_READ: begin
                    if (out_ready) begin
                        if (r_out_row == RW'(N - 1)) begin
                            w_state_nx   = S_DONE;
                            w_out_row_nx = '0;
                        end else begin
                            w_out_row_nx = r_out_row + 1'b1;
                        end
                    end
                end
                S_DONE:  w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Lane i carries element feed_t-i; it is live only while that index is in [0,k).
    always_comb begin
        w_mask_nx = '0;
        w_t       = {1'b0, w_feed_t_nx};
        w_kx      = (TW+1)'(w_k_nx);
        for (int i = 0; i < N; i++) begin
            w_mask_nx[i] = (w_state_nx == S_FEED)
                        && (w_t >= (TW+1)'(i))
                        && ((w_t - (TW+1)'(i)) < w_kx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_feed_t    <= '0;
            r_drain     <= '0;
            r_out_row   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_mask      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_k         <= w_k_nx;
            r_feed_t    <= w_feed_t_nx;
            r_drain     <= w_drain_nx;
            r_out_row   <= w_out_row_nx;
            r_busy      <= (w_state_nx == S_CLEAR) || (w_state_nx == S_FEED)
                        || (w_state_nx == S_DRAIN) || (w_state_nx == S_READ);
            r_done      <= (w_state_nx == S_DONE);
            r_acc_clr   <= (w_state_nx == S_CLEAR);
            r_out_valid <= (w_state_nx == S_READ);
            r_mask      <= w_mask_nx;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign acc_clr   = r_acc_clr;
    assign feed_t    = r_feed_t;
    assign a_valid   = r_mask;
    assign b_valid   = r_mask;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;

endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: directed and randomized commands against a cycle-level
// reference model of the sequencer built from the feed/read timing rules.
module tb_systolic_seq;

    localparam int N      = 4;
    localparam int K_MAX  = 8;
    localparam int PE_LAT = 1;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int TW     = $clog2(K_MAX + 2 * N);
    localparam int RW     = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          acc_clr;
    logic [TW-1:0] feed_t;
    logic [N-1:0]  a_valid;
    logic [N-1:0]  b_valid;
    logic          out_valid;
    logic [RW-1:0] out_row;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    systolic_seq #(
        .N(N), .K_MAX(K_MAX), .PE_LAT(PE_LAT), .KW(KW), .TW(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .abort(abort), .busy(busy), .done(done), .acc_clr(acc_clr),
        .feed_t(feed_t), .a_valid(a_valid), .b_valid(b_valid),
        .out_valid(out_valid), .out_row(out_row), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, acc_clr, out_valid, feed_t,
                    a_valid, b_valid, out_row});
    endfunction

    // Lanes reading an element index t-i inside [0,kk) are live.
    function automatic logic [N-1:0] exp_mask(input int t, input int kk);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            if ((t - i) >= 0 && (t - i) < kk) m[i] = 1'b1;
        end
        return m;
    endfunction

    // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
    task automatic run_cmd(input int klen, input int rmode, input int abort_t,
                           input bit rst_read, input bit noise);
        int kk;
        int acc;
        int cyc;
        bit rdy;
        kk        = (klen > K_MAX) ? K_MAX : klen;
        start     = 1'b1;
        k_len     = KW'(klen);
        out_ready = 1'b0;
        tick();
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        k_len = KW'($urandom_range(0, 15));
        check("clr_pulse", 32'(acc_clr), 1);
        check("clr_busy", 32'(busy), 1);
        check("clr_mask", 32'(a_valid), 0);
        tick();
        if (kk > 0) begin
            for (int t = 0; t <= kk + 2 * N - 3; t++) begin
                check("feed_t", 32'(feed_t), 32'(t));
                check("a_mask", 32'(a_valid), 32'(exp_mask(t, kk)));
                check("b_mask", 32'(b_valid), 32'(exp_mask(t, kk)));
                check("feed_flags", 32'({busy, acc_clr, out_valid}), 32'b100);
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                if (t == abort_t) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    start = 1'b0;
                    check("abort_outs", all_outs(), 0);
                    tick();
                    check("abort_nodone", all_outs(), 0);
                    return;
                end
                tick();
            end
            for (int d = 0; d < PE_LAT; d++) begin
                check("drain_flags", 32'({busy, out_valid, a_valid}), 32'(1 << (N + 1)));
                tick();
            end
        end
        acc = 0;
        cyc = 0;
        while (acc < N && cyc < 200) begin
            check("read_valid", 32'(out_valid), 1);
            check("read_row", 32'(out_row), 32'(acc));
            check("read_flags", 32'({busy, done, a_valid}), 32'(1 << (N + 1)));
            if (rst_read) begin
                rst_n = 1'b0;
                #1;
                check("rst_outs", all_outs(), 0);
                #2;
                rst_n = 1'b1;
                start = 1'b0;
                tick();
                check("rst_idle", all_outs(), 0);
                return;
            end
            unique case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (rdy) acc++;
            cyc++;
        end
        check("read_bound", 32'(cyc < 200), 1);
        start     = 1'b0;
        out_ready = 1'b0;
        check("done_pulse", 32'({done, busy, out_valid}), 32'b100);
        tick();
        check("idle_after", all_outs(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        k_len     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        tick();
        check("reset_idle", all_outs(), 0);

        run_cmd(3, 0, -1, 1'b0, 1'b0);
        run_cmd(3, 1, -1, 1'b0, 1'b0);
        run_cmd(0, 0, -1, 1'b0, 1'b0);
        run_cmd(15, 0, -1, 1'b0, 1'b0);
        run_cmd(8, 0, -1, 1'b0, 1'b0);

        run_cmd(3, 0, 5, 1'b0, 1'b0);
        tick();
        run_cmd(3, 0, -1, 1'b0, 1'b0);

        run_cmd(5, 2, -1, 1'b0, 1'b1);

        start = 1'b1;
        abort = 1'b1;
        k_len = KW'(4);
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort", all_outs(), 0);
        tick();
        check("start_abort_idle", all_outs(), 0);

        run_cmd(2, 0, -1, 1'b1, 1'b0);
        run_cmd(1, 0, -1, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            run_cmd(int'($urandom_range(0, 15)), 2, -1, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
